rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Sequences the single write port of the integer register file.
- Arbitrates round-robin between two writeback sources: EXU results (port 0) and LSU load data (port 1).
- Registers the winning write into a one-cycle output stage that drives the register file wen/waddr/wdata.
- Keeps a per-register busy scoreboard: issue marks a destination busy, the committed write clears it. Decode uses this for RAW/WAW stalls.

Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- exu_valid  in  1  EXU writeback request
- exu_ready  out  1  EXU request granted this cycle
- exu_rd  in  ADDR_WIDTH  EXU destination
- exu_data  in  DATA_WIDTH  EXU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request granted this cycle
- lsu_rd  in  ADDR_WIDTH  LSU destination
- lsu_data  in  DATA_WIDTH  LSU load data
- issue_valid  in  1  decode issuing an instruction that writes issue_rd
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction
- issue_ready  out  1  issue accepted (no WAW conflict)
- rs1_addr, rs2_addr  in  ADDR_WIDTH  decode source indices
- rs1_busy, rs2_busy  out  1  source has a pending write
- flush  in  1  pipeline flush; clears the scoreboard
- rf_wen  out  1  register-file write enable
- rf_waddr  out  ADDR_WIDTH  register-file write index
- rf_wdata  out  DATA_WIDTH  register-file write data

Behaviour:
- Reset (asynchronous, active-high): rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits=0, RR pointer=0 (EXU favoured). Reset asserted mid-operation drops any staged write immediately.
- Arbitration is combinational:
  - Only one source valid: that source is granted.
  - Both valid: the source named by the RR pointer is granted.
  - Pointer update: after a grant made while both sources were valid, the pointer moves to the loser. A single-source grant leaves the pointer unchanged.
- exu_ready/lsu_ready: asserted only for the granted source, and only while that source's valid is high; never both in one cycle. The output stage always accepts, so a grant is a completed handshake.
- Latency: a write accepted in cycle N appears on rf_wen/rf_waddr/rf_wdata in cycle N+1. The register file commits it at the end of N+1. rf_wen=0 in any cycle following a cycle with no grant.
- x0 writes: a granted write to rd==0 completes the handshake, but rf_wen stays 0 and no busy bit is touched.
- Scoreboard set: busy[issue_rd] sets when issue_valid && issue_ready && issue_rd!=0.
- Scoreboard clear: busy[rf_waddr] clears at the clock edge ending a cycle with rf_wen=1. The register-file write and the clear land together, so decode reads correct data the cycle busy falls.
- issue_ready = !busy[issue_rd] || (rf_wen && rf_waddr==issue_rd) || issue_rd==0.
- Simultaneous set and clear of the same index: set wins, and the bit stays 1.
- rs1_busy = busy[rs1_addr], combinational; same for rs2_busy. Both are forced to 0 for index 0.
- flush: clears all busy bits at the next edge and overrides any set in that cycle. The staged output write still commits. The RR pointer is unaffected.
- A busy bit whose write arrives after a flush stays 0.

Optional Feature:
- Macro: RF_WB_SCHED_PERF_EN.
- Defined:
  - Adds two 32-bit output counters, both reset to 0 and wrapping at 2**32.
  - conflict_cnt increments every cycle both exu_valid and lsu_valid are high.
  - stall_cnt increments every cycle issue_valid && !issue_ready.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Test Plan:
- Single EXU write: exu_valid=1, rd=5, data=0x1234 in cycle 0 -> exu_ready=1 in cycle 0; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in cycle 1; rf_wen=0 in cycle 2.
- Contention: both valid for 4 cycles (EXU rd=1, LSU rd=2) from reset -> grant order EXU, LSU, EXU, LSU; exactly one ready per cycle.
- Scoreboard RAW: issue rd=7 in cycle 0; rs1_addr=7 -> rs1_busy=1 from cycle 1. LSU writes rd=7 in cycle 3 -> rf_wen in cycle 4; rs1_busy=0 in cycle 5.
- WAW / same-cycle: busy[9]=1, issue rd=9 with no write -> issue_ready=0. Issue rd=9 in the cycle rf_waddr=9 commits -> issue_ready=1 and busy[9] stays 1.
- x0 and flush: exu write rd=0 -> exu_ready=1 but rf_wen stays 0. Set busy on 3 and 4, pulse flush -> both clear next cycle, with flush winning over a same-cycle issue rd=6.
- Async reset: assert reset mid-cycle while rf_wen=1 -> rf_wen drops to 0 without waiting for a clock edge, and the busy bits clear.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler
//
// Purpose:
//   Sequences the single write port of the integer register file. Two
//   writeback sources (EXU = port 0, LSU = port 1) are arbitrated round-robin.
//   The winner is registered into a one-cycle output stage that drives the
//   register file. A per-register busy scoreboard is set on issue and cleared
//   when the staged write commits; decode uses it for RAW/WAW stalls.
//
// Ports:
//   clock, reset           system clock, asynchronous active-high reset
//   exu_valid/ready/rd/data  EXU writeback request and grant
//   lsu_valid/ready/rd/data  LSU writeback request and grant
//   issue_valid/rd/ready     decode issue of a register-writing instruction
//   rs1_addr/rs2_addr        decode source indices
//   rs1_busy/rs2_busy        source has a pending write
//   flush                    clears the whole scoreboard
//   rf_wen/waddr/wdata       registered register-file write port
//
// Optional feature (macro RF_WB_SCHED_PERF_EN):
//   Adds conflict_cnt (cycles with both sources valid) and stall_cnt
//   (cycles with issue_valid && !issue_ready), 32-bit wrapping counters.
// -----------------------------------------------------------------------------
module rf_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  flush,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef RF_WB_SCHED_PERF_EN
  ,
  output logic [31:0]           conflict_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = {ADDR_WIDTH{1'b0}};

  // rr_q = 0 favours EXU on contention, 1 favours LSU
  logic                  rr_q, rr_d;
  logic                  exu_gnt, lsu_gnt, any_gnt, both_valid;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  // Round-robin arbitration and pointer update
  always_comb begin
    both_valid = exu_valid & lsu_valid;
    exu_gnt    = exu_valid & (~lsu_valid | ~rr_q);
    lsu_gnt    = lsu_valid & (~exu_valid | rr_q);
    any_gnt    = exu_gnt | lsu_gnt;
    // After a contended grant, point at the loser
    if (both_valid) begin
      rr_d = exu_gnt;
    end else begin
      rr_d = rr_q;
    end
  end

  assign exu_ready = exu_gnt;
  assign lsu_ready = lsu_gnt;

  // Winner selection into the output stage; x0 writes handshake but never write
  always_comb begin
    if (lsu_gnt) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end else begin
      sel_rd   = exu_rd;
      sel_data = exu_data;
    end
    wen_d = any_gnt && (sel_rd != X0);
    if (any_gnt) begin
      waddr_d = sel_rd;
      wdata_d = sel_data;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // WAW check; a write committing this cycle frees its register for re-issue
  always_comb begin
    issue_ready = !busy_q[issue_rd] || (wen_q && (waddr_q == issue_rd)) || (issue_rd == X0);
  end

  // Scoreboard next state: clear on commit, then set on issue (set wins), flush overrides all
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = {NREG{1'b0}};
    end else begin
      if (wen_q) begin
        busy_d[waddr_q] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (issue_valid && issue_ready && (issue_rd != X0)) begin
        busy_d[issue_rd] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // Source lookups; x0 is never busy
  always_comb begin
    rs1_busy = (rs1_addr != X0) && busy_q[rs1_addr];
    rs2_busy = (rs2_addr != X0) && busy_q[rs2_addr];
  end

  // State registers: pointer, output stage, scoreboard
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= X0;
      wdata_q <= {DATA_WIDTH{1'b0}};
      busy_q  <= {NREG{1'b0}};
    end else begin
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

`ifdef RF_WB_SCHED_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic [31:0] stall_q, stall_d;

  // Counter increments; natural 32-bit wrap
  always_comb begin
    if (both_valid) begin
      conflict_d = conflict_q + 32'd1;
    end else begin
      conflict_d = conflict_q;
    end
    if (issue_valid && !issue_ready) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= 32'd0;
      stall_q    <= 32'd0;
    end else begin
      conflict_q <= conflict_d;
      stall_q    <= stall_d;
    end
  end

  assign conflict_cnt = conflict_q;
  assign stall_cnt    = stall_q;
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_scheduler
//
// Self-checking bench for rf_wb_scheduler: a table of directed vectors for
// the single write and contention cases, hand-written sequences for the
// scoreboard, x0, flush and asynchronous reset corners, and a randomized run
// checked against a behavioural model of the scheduling rules.
// -----------------------------------------------------------------------------
module tb_rf_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        exu_valid, lsu_valid, issue_valid, flush;
  logic        exu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy, rf_wen;
  logic [4:0]  exu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr, rf_waddr;
  logic [31:0] exu_data, lsu_data, rf_wdata;
`ifdef RF_WB_SCHED_PERF_EN
  logic [31:0] conflict_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rf_wb_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RF_WB_SCHED_PERF_EN
    , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; flush = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_lsu_first;   // which source wins the next contended cycle
  bit          m_busy[32];
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic m_reset();
    m_lsu_first = 1'b0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
  endtask

  function automatic bit m_exu_wins();
    if (exu_valid && lsu_valid) return !m_lsu_first;
    return exu_valid;
  endfunction

  function automatic bit m_lsu_wins();
    if (exu_valid && lsu_valid) return m_lsu_first;
    return lsu_valid;
  endfunction

  function automatic bit m_issue_ok();
    if (issue_rd == 5'd0) return 1'b1;
    if (!m_busy[issue_rd]) return 1'b1;
    return m_wen && (m_waddr == issue_rd);
  endfunction

  function automatic bit m_src_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply one clock edge to the model with the currently driven inputs
  task automatic m_edge();
    bit eg, lg, ok;
    eg = m_exu_wins();
    lg = m_lsu_wins();
    ok = m_issue_ok();
    if (m_wen) m_busy[m_waddr] = 1'b0;
    if (issue_valid && ok && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    if (flush) foreach (m_busy[i]) m_busy[i] = 1'b0;
    if (exu_valid && lsu_valid) m_lsu_first = eg;
    if (eg) begin
      m_wen = (exu_rd != 5'd0); m_waddr = exu_rd; m_wdata = exu_data;
    end else if (lg) begin
      m_wen = (lsu_rd != 5'd0); m_waddr = lsu_rd; m_wdata = lsu_data;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    rs1_addr = 5'd5;
    #2;
    chk("reset_wen", rf_wen, 1'b0);
    chk("reset_waddr", rf_waddr, 5'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_busy", rs1_busy, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        x_er;
    logic        x_lr;
    logic        x_wen;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // single EXU write, then four contended cycles from the reset pointer
    tbl[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5, 32'h1234};
    tbl[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[4] = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1};
    tbl[5] = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB2};
    tbl[6] = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1};
    tbl[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd2, 32'hB2};
    tbl[8] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      #3;
      chk($sformatf("tbl%0d_exu_ready", i), exu_ready, tbl[i].x_er);
      chk($sformatf("tbl%0d_lsu_ready", i), lsu_ready, tbl[i].x_lr);
      chk($sformatf("tbl%0d_rf_wen", i), rf_wen, tbl[i].x_wen);
      if (tbl[i].x_wen) begin
        chk($sformatf("tbl%0d_rf_waddr", i), rf_waddr, tbl[i].x_wa);
        chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].x_wd);
      end
      next();
    end

    // ---------------- RAW through the scoreboard ----------------
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; #3;
    chk("raw_issue_ready", issue_ready, 1'b1);
    chk("raw_c0_busy", rs1_busy, 1'b0);
    next();
    issue_valid = 1'b0; #3;
    chk("raw_c1_busy", rs1_busy, 1'b1);
    next();
    #3;
    chk("raw_c2_busy", rs1_busy, 1'b1);
    next();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77; #3;
    chk("raw_lsu_ready", lsu_ready, 1'b1);
    next();
    lsu_valid = 1'b0; #3;
    chk("raw_c4_wen", rf_wen, 1'b1);
    chk("raw_c4_waddr", rf_waddr, 5'd7);
    chk("raw_c4_wdata", rf_wdata, 32'h77);
    chk("raw_c4_busy", rs1_busy, 1'b1);
    next();
    #3;
    chk("raw_c5_busy", rs1_busy, 1'b0);
    chk("raw_c5_wen", rf_wen, 1'b0);
    next();

    // ---------------- WAW and same-cycle set/clear ----------------
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9; #3;
    chk("waw_first_issue", issue_ready, 1'b1);
    next();
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99; #3;
    chk("waw_blocked", issue_ready, 1'b0);
    chk("waw_exu_ready", exu_ready, 1'b1);
    next();
    exu_valid = 1'b0; #3;
    chk("waw_commit_wen", rf_wen, 1'b1);
    chk("waw_commit_ready", issue_ready, 1'b1);
    next();
    issue_valid = 1'b0; rs2_addr = 5'd9; #3;
    chk("waw_set_wins", rs2_busy, 1'b1);
    next();

    // ---------------- x0 write ----------------
    idle();
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h55; #3;
    chk("x0_exu_ready", exu_ready, 1'b1);
    next();
    exu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; #3;
    chk("x0_no_wen", rf_wen, 1'b0);
    chk("x0_rs1_busy", rs1_busy, 1'b0);
    chk("x0_issue_ready", issue_ready, 1'b1);
    next();

    // ---------------- flush ----------------
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3; #3;
    next();
    issue_rd = 5'd4; exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 32'hC0DE; #3;
    next();
    exu_valid = 1'b0; issue_rd = 5'd6; flush = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd4; #3;
    chk("flush_pre_b3", rs1_busy, 1'b1);
    chk("flush_pre_b4", rs2_busy, 1'b1);
    chk("flush_staged_wen", rf_wen, 1'b1);
    chk("flush_staged_waddr", rf_waddr, 5'd12);
    next();
    issue_valid = 1'b0; flush = 1'b0; #3;
    chk("flush_b3", rs1_busy, 1'b0);
    chk("flush_b4", rs2_busy, 1'b0);
    next();
    rs1_addr = 5'd6; rs2_addr = 5'd9; #3;
    chk("flush_b6_over_issue", rs1_busy, 1'b0);
    chk("flush_b9", rs2_busy, 1'b0);
    next();

    // ---------------- asynchronous reset mid-cycle ----------------
    idle();
    issue_valid = 1'b1; issue_rd = 5'd8; #3;
    next();
    issue_valid = 1'b0; exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hAB; #3;
    next();
    exu_valid = 1'b0; rs1_addr = 5'd8; #1;
    chk("areset_pre_wen", rf_wen, 1'b1);
    chk("areset_pre_busy", rs1_busy, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_wen", rf_wen, 1'b0);
    chk("areset_waddr", rf_waddr, 5'd0);
    chk("areset_busy", rs1_busy, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      exu_valid   = 1'($urandom_range(0, 1));
      exu_rd      = 5'($urandom_range(0, 7));
      exu_data    = $urandom;
      lsu_valid   = 1'($urandom_range(0, 1));
      lsu_rd      = 5'($urandom_range(0, 7));
      lsu_data    = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 31) == 0);
      #3;
      chk("rnd_exu_ready", exu_ready, m_exu_wins());
      chk("rnd_lsu_ready", lsu_ready, m_lsu_wins());
      chk("rnd_issue_ready", issue_ready, m_issue_ok());
      chk("rnd_rs1_busy", rs1_busy, m_src_busy(rs1_addr));
      chk("rnd_rs2_busy", rs2_busy, m_src_busy(rs2_addr));
      chk("rnd_rf_wen", rf_wen, m_wen);
      if (m_wen) begin
        chk("rnd_rf_waddr", rf_waddr, m_waddr);
        chk("rnd_rf_wdata", rf_wdata, m_wdata);
      end
      m_edge();
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
